uart_rx: RTL

Serial receiver that pairs with the existing transmitter on the ESP32/PC UART link. It samples the asynchronous `rxd` line, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit), and presents each byte on `data_i`. It signals each new byte with a one-cycle `receive_ack` pulse, which is the same strobe the transmitter consumes to launch a send. Framing errors are flagged and never produce an ack.

---
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver for the ESP32/PC link. Synchronises the
//            asynchronous rxd line, locates the start-bit mid-point, samples
//            eight data bits (LSB first) and the stop bit one bit period
//            apart, and publishes each good byte with a one-cycle strobe.
//            A low stop bit raises a one-cycle framing-error pulse instead,
//            and the receiver then waits for the line to return high so a
//            held-low (break) line cannot produce spurious frames.
// Ports    : clk          in   system clock (only clock)
//            rst          in   synchronous, active-high reset
//            rxd          in   asynchronous serial input, idle high
//            data_i       out  [7:0] last correctly received byte
//            receive_ack  out  one-cycle pulse, data_i updated this cycle
//            frame_err    out  one-cycle pulse, stop bit sampled low
//            LEDmind      out  toggles on every receive_ack
// Params   : CLKS_PER_BIT clock cycles per UART bit, must be >= 4
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_i,
    output logic       receive_ack,
    output logic       frame_err,
    output logic       LEDmind
);

    // Start-edge to start-bit mid-point distance; derived from the bit period.
    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(HALF_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [2:0]         c_bit_last  = 3'd7;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    logic [1:0]         r_sync;
    logic               w_rx_s;

    logic [2:0]         r_state,   w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shreg,   w_shreg_nxt;
    logic [7:0]         r_data,    w_data_nxt;
    logic               r_ack,     w_ack_nxt;
    logic               r_ferr,    w_ferr_nxt;
    logic               r_led,     w_led_nxt;

    // Two-flop synchroniser; resets to the idle (high) line level so a
    // reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
            r_data    <= 8'h00;
            r_ack     <= 1'b0;
            r_ferr    <= 1'b0;
            r_led     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shreg   <= w_shreg_nxt;
            r_data    <= w_data_nxt;
            r_ack     <= w_ack_nxt;
            r_ferr    <= w_ferr_nxt;
            r_led     <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        w_data_nxt    = r_data;
        w_ack_nxt     = 1'b0;
        w_ferr_nxt    = 1'b0;
        w_led_nxt     = r_led;

        case (r_state)
            c_st_idle: begin
                if (!w_rx_s) begin
                    w_state_nxt = c_st_start;
                    w_cnt_nxt   = '0;
                end
            end

            // The line is only judged at the start-bit mid-point; a low
            // pulse that has already ended by then is discarded silently.
            c_st_start: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt   = c_st_data;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            // Bits enter at the MSB and move right, so bit 0 ends in [0].
            c_st_data: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
                    if (r_bit_idx == c_bit_last) begin
                        w_state_nxt = c_st_stop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            // Returning to idle at the stop mid-point leaves half a bit of
            // margin before the next start edge of a back-to-back frame.
            c_st_stop: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shreg;
                        w_ack_nxt   = 1'b1;
                        w_led_nxt   = ~r_led;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = c_st_break;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            c_st_break: begin
                if (w_rx_s) begin
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign data_i      = r_data;
    assign receive_ack = r_ack;
    assign frame_err   = r_ferr;
    assign LEDmind     = r_led;

endmodule
`default_nettype wire
